// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: fetch over imem, decode/execute, dmem access,
// write-back strobe and next-PC generation, with a sticky fault on timeout or misaligned PC.
//
// state  | meaning
// FETCH  | request instruction at pc (gated by run)
// WAIT_I | wait for imem response, latch instruction
// DECODE | decoder settle cycle
// EXEC   | route to MEM (load/store) or WB
// MEM    | hold dmem request until accepted
// WAIT_D | wait for load data / store ack
// WB     | rf_we strobe, retire, pc update
// FAULT  | absorbing until reset
module core_ctrl_fsm #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr_o,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_is_branch,
    input  logic        dec_is_jump,
    input  logic        dec_is_jalr,
    input  logic [31:0] dec_imm,
    input  logic        branch_taken,
    input  logic [31:0] alu_result,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    input  logic        dmem_rsp_valid,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        fault
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_WAIT_I = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WAIT_D = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [7:0]  TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic [7:0]  r_wait_cnt;
    logic        r_fault;

    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic [7:0]  w_wait_inc;
    logic        w_timeout;

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (dec_is_jalr) begin
            w_next_pc = alu_result & 32'hFFFF_FFFE;
        end else if (dec_is_jump || (dec_is_branch && branch_taken)) begin
            w_next_pc = r_pc + dec_imm;
        end
    end

    assign w_misaligned = |w_next_pc[1:0];
    // Counter holds completed wait cycles; the cycle that would reach the limit faults.
    assign w_wait_inc   = r_wait_cnt + 8'd1;
    assign w_timeout    = (w_wait_inc == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_instret  <= 32'd0;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (run && imem_req_ready) begin
                        r_state    <= S_WAIT_I;
                        r_wait_cnt <= 8'd0;
                    end
                end
                S_WAIT_I: begin
                    if (imem_rsp_valid) begin
                        r_instr <= imem_rsp_data;
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    r_wait_cnt <= 8'd0;
                    r_state    <= (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_req_ready) begin
                        r_state    <= S_WAIT_D;
                        r_wait_cnt <= 8'd0;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                S_WAIT_D: begin
                    if (dmem_rsp_valid) begin
                        r_state <= S_WB;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                    end
                end
                S_WB: begin
                    if (w_misaligned) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_pc      <= w_next_pc;
                        r_instret <= r_instret + 32'd1;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req_valid = (r_state == S_FETCH) && run;
    assign imem_addr      = r_pc;
    assign instr_o        = r_instr;
    assign dmem_req_valid = (r_state == S_MEM);
    assign dmem_we        = (r_state == S_MEM) && dec_mem_write;
    assign rf_we          = (r_state == S_WB) && dec_reg_write && !w_misaligned;
    assign retire         = (r_state == S_WB) && !w_misaligned;
    assign pc             = r_pc;
    assign instret        = r_instret;
    assign fault          = r_fault;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Self-checking bench for core_ctrl_fsm: memory/decoder stand-in, scoreboard of
// expected per-instruction outcomes, and directed reset/timeout scenarios.
module tb_core_ctrl_fsm;
    logic        clk, rst_n, run;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data, instr_o;
    logic        dec_mem_read, dec_mem_write, dec_reg_write;
    logic        dec_is_branch, dec_is_jump, dec_is_jalr;
    logic [31:0] dec_imm, alu_result;
    logic        branch_taken;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic        rf_we, retire, fault;
    logic [31:0] pc, instret;

    core_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_o(instr_o),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_is_branch(dec_is_branch),
        .dec_is_jump(dec_is_jump), .dec_is_jalr(dec_is_jalr), .dec_imm(dec_imm),
        .branch_taken(branch_taken), .alu_result(alu_result),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_rsp_valid(dmem_rsp_valid), .rf_we(rf_we),
        .pc(pc), .retire(retire), .instret(instret), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic rd, wr, rw, br, jp, jr;
        logic [31:0] imm;
        logic tk;
        logic [31:0] alu;
        int dq, dr;
    } stim_t;

    typedef struct {
        logic [31:0] pc, instret, addr, instr;
        int rfwe, rfwe_cyc, retire, cyc, dvalid;
        logic fault, we;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_pc, m_instret;

    logic [31:0] obs_pc, obs_instret, obs_addr, obs_instr;
    int          obs_rfwe, obs_rfwe_cyc, obs_retire, obs_cyc, obs_dvalid;
    logic        obs_fault, obs_we;

    function automatic stim_t mk(input logic [31:0] ins, input logic rd, wr, rw, br, jp, jr,
                                 input logic [31:0] imm, input logic tk, input logic [31:0] alu,
                                 input int dq, input int dr);
        stim_t s;
        s.ins = ins; s.rd = rd; s.wr = wr; s.rw = rw; s.br = br; s.jp = jp; s.jr = jr;
        s.imm = imm; s.tk = tk; s.alu = alu; s.dq = dq; s.dr = dr;
        return s;
    endfunction

    task automatic do_reset(input logic run_v);
        rst_n = 1'b0; run = run_v;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 32'hDEAD_BEEF;
        dec_mem_read = 0; dec_mem_write = 0; dec_reg_write = 0;
        dec_is_branch = 0; dec_is_jump = 0; dec_is_jalr = 0; dec_imm = 0;
        branch_taken = 0; alu_result = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0; m_instret = 32'h0;
        sb_q.delete();
    endtask

    // Model the expected outcome, push it, then act as memory until retire or fault.
    task automatic do_instr(input stim_t s);
        exp_t        e;
        logic [31:0] npc;
        logic        mis, mem, done, rsp_pend, d_wait;
        int          dcnt, rcnt;
        npc = s.jr ? {s.alu[31:1], 1'b0} :
              (s.jp || (s.br && s.tk)) ? m_pc + s.imm : m_pc + 32'd4;
        mis = (npc[1:0] != 2'b00);
        mem = s.rd || s.wr;
        e.pc       = mis ? m_pc : npc;
        e.instret  = m_instret + (mis ? 32'd0 : 32'd1);
        e.addr     = m_pc;
        e.instr    = s.ins;
        e.rfwe     = (s.rw && !mis) ? 1 : 0;
        e.retire   = mis ? 0 : 1;
        e.fault    = mis;
        e.cyc      = (mem ? 7 + s.dq + s.dr : 5) + (mis ? 1 : 0);
        e.rfwe_cyc = e.rfwe ? e.cyc : 0;
        e.dvalid   = mem ? s.dq + 1 : 0;
        e.we       = s.wr;
        sb_q.push_back(e);
        m_pc = e.pc; m_instret = e.instret;

        dec_mem_read = s.rd; dec_mem_write = s.wr; dec_reg_write = s.rw;
        dec_is_branch = s.br; dec_is_jump = s.jp; dec_is_jalr = s.jr;
        dec_imm = s.imm; branch_taken = s.tk; alu_result = s.alu;
        obs_rfwe = 0; obs_rfwe_cyc = 0; obs_retire = 0; obs_cyc = -1; obs_dvalid = 0;
        obs_we = 0; obs_addr = 32'hX; obs_instr = 32'hX;
        done = 0; rsp_pend = 0; d_wait = 0; dcnt = 0; rcnt = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (c == 1) obs_addr = imem_addr;
            if (rf_we) begin obs_rfwe++; obs_rfwe_cyc = c; end
            if (dmem_req_valid) begin obs_dvalid++; if (dmem_we) obs_we = 1; end
            if (retire) obs_retire++;
            if (retire || fault) begin done = 1; obs_cyc = c; obs_instr = instr_o; end
            imem_rsp_valid = rsp_pend;
            imem_rsp_data  = rsp_pend ? s.ins : 32'hDEAD_BEEF;
            rsp_pend       = imem_req_valid;
            imem_req_ready = imem_req_valid;
            dmem_rsp_valid = 0;
            if (d_wait) begin
                if (rcnt == s.dr) begin dmem_rsp_valid = 1; d_wait = 0; end
                else rcnt++;
            end
            dmem_req_ready = 0;
            if (dmem_req_valid) begin
                if (dcnt == s.dq) begin dmem_req_ready = 1; d_wait = 1; rcnt = 0; end
                else dcnt++;
            end
        end
        @(posedge clk); #1;
        obs_pc = pc; obs_instret = instret; obs_fault = fault;
    endtask

    task automatic test_reset;
        int bad;
        do_reset(1'b0);
        #1;
        n_checks++; if (pc !== 32'h0 || instret !== 32'h0) begin n_fail++; $display("FAIL reset pc/instret: got %h/%h expected 0/0", pc, instret); end
        n_checks++; if (instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset instr_o: got %h expected 00000013", instr_o); end
        n_checks++; if ({imem_req_valid, dmem_req_valid, dmem_we, rf_we, retire, fault} !== 6'b0) begin
            n_fail++; $display("FAIL reset strobes: got %b expected 000000", {imem_req_valid, dmem_req_valid, dmem_we, rf_we, retire, fault}); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req_valid !== 1'b0 || pc !== 32'h0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL run0_gate: got %0d bad cycles expected 0", bad); end
        run = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL run1_req: got valid=%b addr=%h expected 1/0", imem_req_valid, imem_addr); end
    endtask

    task automatic test_alu_branch;
        stim_t tq[$];
        exp_t  e;
        do_reset(1'b1);
        tq.push_back(mk(32'h0010_0093, 0, 0, 1, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0)); // ADDI 0x0 -> 0x4
        tq.push_back(mk(32'h0FC0_00EF, 0, 0, 1, 0, 1, 0, 32'h0000_00FC, 0, 32'h0,  0, 0)); // JAL -> 0x100
        tq.push_back(mk(32'hFE00_0CE3, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFF8, 1, 32'h0,  0, 0)); // BEQ taken -> 0xF8
        tq.push_back(mk(32'h0080_006F, 0, 0, 0, 0, 1, 0, 32'h0000_0008, 0, 32'h0,  0, 0)); // JAL -> 0x100
        tq.push_back(mk(32'hFE00_0CE3, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFF8, 0, 32'h0,  0, 0)); // BEQ not taken -> 0x104
        tq.push_back(mk(32'hEF9F_F06F, 0, 0, 0, 0, 1, 0, 32'hFFFF_FEF8, 0, 32'h0,  0, 0)); // JAL -> 0xFFFFFFFC
        tq.push_back(mk(32'h0010_0093, 0, 0, 1, 0, 0, 0, 32'h0,         0, 32'h0,  0, 0)); // ADDI wraps to 0x0
        tq.push_back(mk(32'h0000_80E7, 0, 0, 1, 0, 1, 1, 32'h0000_0100, 0, 32'h41, 0, 0)); // jalr beats jump -> 0x40
        tq.push_back(mk(32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0000_0100, 1, 32'h0,  0, 0)); // taken w/o branch -> 0x44
        foreach (tq[i]) begin
            do_instr(tq[i]);
            e = sb_q.pop_front();
            n_checks++; if (obs_pc !== e.pc) begin n_fail++; $display("FAIL alu[%0d] pc: got %h expected %h", i, obs_pc, e.pc); end
            n_checks++; if (obs_instret !== e.instret) begin n_fail++; $display("FAIL alu[%0d] instret: got %0d expected %0d", i, obs_instret, e.instret); end
            n_checks++; if (obs_addr !== e.addr) begin n_fail++; $display("FAIL alu[%0d] imem_addr: got %h expected %h", i, obs_addr, e.addr); end
            n_checks++; if (obs_instr !== e.instr) begin n_fail++; $display("FAIL alu[%0d] instr_o: got %h expected %h", i, obs_instr, e.instr); end
            n_checks++; if (obs_rfwe != e.rfwe || obs_rfwe_cyc != e.rfwe_cyc) begin n_fail++; $display("FAIL alu[%0d] rf_we: got %0d@%0d expected %0d@%0d", i, obs_rfwe, obs_rfwe_cyc, e.rfwe, e.rfwe_cyc); end
            n_checks++; if (obs_retire != e.retire || obs_fault !== e.fault) begin n_fail++; $display("FAIL alu[%0d] retire/fault: got %0d/%b expected %0d/%b", i, obs_retire, obs_fault, e.retire, e.fault); end
            n_checks++; if (obs_cyc != e.cyc) begin n_fail++; $display("FAIL alu[%0d] cycles: got %0d expected %0d", i, obs_cyc, e.cyc); end
            n_checks++; if (obs_dvalid != e.dvalid) begin n_fail++; $display("FAIL alu[%0d] dmem_valid: got %0d expected %0d", i, obs_dvalid, e.dvalid); end
        end
    endtask

    task automatic test_load_store;
        stim_t tq[$];
        exp_t  e;
        do_reset(1'b1);
        tq.push_back(mk(32'h0000_2083, 1, 0, 1, 0, 0, 0, 32'h0, 0, 32'h10, 0, 0)); // LW zero wait
        tq.push_back(mk(32'h0040_2103, 1, 0, 1, 0, 0, 0, 32'h4, 0, 32'h14, 3, 2)); // LW ready late, rsp late
        tq.push_back(mk(32'h0020_2423, 0, 1, 0, 0, 0, 0, 32'h8, 0, 32'h18, 1, 0)); // SW
        tq.push_back(mk(32'h0020_2623, 1, 1, 0, 0, 0, 0, 32'hC, 0, 32'h1C, 0, 1)); // both flags -> store
        foreach (tq[i]) begin
            do_instr(tq[i]);
            e = sb_q.pop_front();
            n_checks++; if (obs_pc !== e.pc || obs_instret !== e.instret) begin n_fail++; $display("FAIL mem[%0d] pc/instret: got %h/%0d expected %h/%0d", i, obs_pc, obs_instret, e.pc, e.instret); end
            n_checks++; if (obs_dvalid != e.dvalid) begin n_fail++; $display("FAIL mem[%0d] dmem_valid cycles: got %0d expected %0d", i, obs_dvalid, e.dvalid); end
            n_checks++; if (obs_we !== e.we) begin n_fail++; $display("FAIL mem[%0d] dmem_we: got %b expected %b", i, obs_we, e.we); end
            n_checks++; if (obs_rfwe != e.rfwe || obs_rfwe_cyc != e.rfwe_cyc) begin n_fail++; $display("FAIL mem[%0d] rf_we: got %0d@%0d expected %0d@%0d", i, obs_rfwe, obs_rfwe_cyc, e.rfwe, e.rfwe_cyc); end
            n_checks++; if (obs_cyc != e.cyc) begin n_fail++; $display("FAIL mem[%0d] cycles: got %0d expected %0d", i, obs_cyc, e.cyc); end
            n_checks++; if (obs_retire != e.retire || obs_fault !== e.fault) begin n_fail++; $display("FAIL mem[%0d] retire/fault: got %0d/%b expected %0d/%b", i, obs_retire, obs_fault, e.retire, e.fault); end
        end
    endtask

    task automatic test_jalr_fault;
        stim_t tq[$];
        exp_t  e;
        int    bad;
        do_reset(1'b1);
        tq.push_back(mk(32'h0000_80E7, 0, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0000_0201, 0, 0)); // -> 0x200
        tq.push_back(mk(32'h0000_80E7, 0, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0000_0203, 0, 0)); // 0x202 -> fault
        foreach (tq[i]) begin
            do_instr(tq[i]);
            e = sb_q.pop_front();
            n_checks++; if (obs_pc !== e.pc || obs_instret !== e.instret) begin n_fail++; $display("FAIL jalr[%0d] pc/instret: got %h/%0d expected %h/%0d", i, obs_pc, obs_instret, e.pc, e.instret); end
            n_checks++; if (obs_fault !== e.fault || obs_retire != e.retire) begin n_fail++; $display("FAIL jalr[%0d] fault/retire: got %b/%0d expected %b/%0d", i, obs_fault, obs_retire, e.fault, e.retire); end
            n_checks++; if (obs_rfwe != e.rfwe) begin n_fail++; $display("FAIL jalr[%0d] rf_we: got %0d expected %0d", i, obs_rfwe, e.rfwe); end
            n_checks++; if (obs_cyc != e.cyc) begin n_fail++; $display("FAIL jalr[%0d] cycles: got %0d expected %0d", i, obs_cyc, e.cyc); end
        end
        bad = 0;
        imem_req_ready = 1; dmem_req_ready = 1; imem_rsp_valid = 1; dmem_rsp_valid = 1;
        repeat (10) begin
            @(negedge clk);
            if (!fault || imem_req_valid || dmem_req_valid || rf_we || retire || pc !== 32'h200) bad++;
        end
        imem_req_ready = 0; dmem_req_ready = 0; imem_rsp_valid = 0; dmem_rsp_valid = 0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fault_absorb: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_timeout;
        int k;
        do_reset(1'b1);
        @(negedge clk); imem_req_ready = 1;
        @(posedge clk); #1; imem_req_ready = 0;
        k = 0;
        while (!fault && k < 400) begin @(posedge clk); #1; k++; end
        n_checks++; if (k != 255) begin n_fail++; $display("FAIL imem_timeout: got fault after %0d cycles expected 255", k); end
        n_checks++; if (imem_req_valid !== 1'b0 || retire !== 1'b0) begin n_fail++; $display("FAIL timeout_quiet: got valid=%b retire=%b expected 0/0", imem_req_valid, retire); end
        // A response on the last allowed cycle must still be taken.
        do_reset(1'b1);
        @(negedge clk); imem_req_ready = 1;
        @(posedge clk); #1; imem_req_ready = 0;
        repeat (254) @(posedge clk);
        #1; imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5013;
        @(posedge clk); #1; imem_rsp_valid = 0;
        n_checks++; if (fault !== 1'b0 || instr_o !== 32'h1234_5013) begin n_fail++; $display("FAIL last_cycle_rsp: got fault=%b instr=%h expected 0/12345013", fault, instr_o); end
    endtask

    task automatic test_reset_midflight;
        do_reset(1'b1);
        do_instr(mk(32'h0010_0093, 0, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
        void'(sb_q.pop_front());
        dec_mem_read = 1; dec_reg_write = 1;
        @(negedge clk); imem_req_ready = 1;
        @(negedge clk); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0040_2083;
        @(negedge clk); imem_rsp_valid = 0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL load_req: got valid=%b we=%b expected 1/0", dmem_req_valid, dmem_we); end
        dmem_req_ready = 1;
        @(negedge clk); dmem_req_ready = 0;
        n_checks++; if (dmem_req_valid !== 1'b0 || pc !== 32'h4) begin n_fail++; $display("FAIL wait_d: got valid=%b pc=%h expected 0/00000004", dmem_req_valid, pc); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0 || instret !== 32'h0 || instr_o !== 32'h0000_0013) begin
            n_fail++; $display("FAIL async_reset: got pc=%h instret=%0d instr=%h expected 0/0/00000013", pc, instret, instr_o); end
        n_checks++; if ({dmem_req_valid, dmem_we, rf_we, retire, fault} !== 5'b0) begin n_fail++; $display("FAIL async_reset strobes: got %b expected 00000", {dmem_req_valid, dmem_we, rf_we, retire, fault}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_branch();
        test_load_store();
        test_jalr_fault();
        test_timeout();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
